// File: rtl/edge_detector_conv_pkg.sv
// Shared types and constants for the 3x3 gradient edge detector.
// Holds the FSM state type, width defaults and kernel geometry helpers.
package edge_detector_conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int PIX_W_DEF = 8;
    localparam int ACC_W_DEF = 11;
    localparam int KSIZE     = 3;
    localparam int NTAPS     = 9;

    localparam logic [3:0] LAST_TAP = 4'(NTAPS - 1);

    // Taps are walked row-major, so the tap number splits into row and column.
    function automatic logic [2:0] tap_row(input logic [3:0] idx);
        return 3'(idx / 4'(KSIZE));
    endfunction

    function automatic logic [2:0] tap_col(input logic [3:0] idx);
        return 3'(idx % 4'(KSIZE));
    endfunction

endpackage

// File: rtl/edge_detector_mag.sv
// Combinational gradient magnitude: |gx| + |gy|, clamped to the pixel range.
// The sum is formed one bit wider than the gradients so it can never wrap.
module edge_detector_mag
    import edge_detector_conv_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] gx,
    input  logic signed [ACC_W-1:0] gy,
    output logic        [PIX_W-1:0] mag
);

    function automatic logic [ACC_W:0] abs_ext(input logic signed [ACC_W-1:0] v);
        logic [ACC_W:0] w;
        w = {v[ACC_W-1], v};
        if (v[ACC_W-1]) begin
            return ~w + (ACC_W+1)'(1);
        end
        return w;
    endfunction

    function automatic logic [PIX_W-1:0] sat_pix(input logic [ACC_W:0] s);
        if (|s[ACC_W:PIX_W]) begin
            return '1;
        end
        return s[PIX_W-1:0];
    endfunction

    logic [ACC_W:0] sum_abs;

    assign sum_abs = abs_ext(gx) + abs_ext(gy);
    assign mag     = sat_pix(sum_abs);

endmodule

// File: rtl/edge_detector_conv.sv
// Sequential 3x3 gradient convolver: one tap per cycle against an external
// coefficient lookup, then holds Gx/Gy/magnitude until downstream accepts.
module edge_detector_conv
    import edge_detector_conv_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    Clk_i,
    input  logic                    Rst_i,
    input  logic [9*PIX_W-1:0]      Window_i,
    input  logic                    Valid_i,
    output logic                    Ready_o,
    output logic [2:0]              Xindex_o,
    output logic [2:0]              Yindex_o,
    input  logic [2:0]              Kx_i,
    input  logic [2:0]              Ky_i,
    output logic signed [ACC_W-1:0] Gx_o,
    output logic signed [ACC_W-1:0] Gy_o,
    output logic [PIX_W-1:0]        Mag_o,
    output logic                    Valid_o,
    input  logic                    Ready_i
);

    state_t state, state_nxt;
    logic   capture;
    logic   acc_en;

    logic [9*PIX_W-1:0]      window_p0;
    logic [3:0]              idx;
    logic signed [ACC_W-1:0] gx_p1, gy_p1;

    logic [PIX_W-1:0]        pix_cur;
    logic signed [ACC_W-1:0] pix_ext, kx_ext, ky_ext;
    logic signed [ACC_W-1:0] prod_x, prod_y;

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Ready_o   = 1'b0;
        Valid_o   = 1'b0;
        capture   = 1'b0;
        acc_en    = 1'b0;
        Xindex_o  = 3'd0;
        Yindex_o  = 3'd0;
        case (state)
            IDLE: begin
                Ready_o = 1'b1;
                if (Valid_i) begin
                    capture   = 1'b1;
                    state_nxt = ACC;
                end
            end
            ACC: begin
                acc_en   = 1'b1;
                Xindex_o = tap_row(idx);
                Yindex_o = tap_col(idx);
                if (idx == LAST_TAP) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                Valid_o = 1'b1;
                if (Ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0 -> p1: unsigned pixel times signed coefficient, both widened first
    assign pix_cur = window_p0[idx*PIX_W +: PIX_W];
    assign pix_ext = {{(ACC_W-PIX_W){1'b0}}, pix_cur};
    assign kx_ext  = {{(ACC_W-3){Kx_i[2]}}, Kx_i};
    assign ky_ext  = {{(ACC_W-3){Ky_i[2]}}, Ky_i};
    assign prod_x  = pix_ext * kx_ext;
    assign prod_y  = pix_ext * ky_ext;

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            idx   <= '0;
            gx_p1 <= '0;
            gy_p1 <= '0;
        end else if (capture) begin
            window_p0 <= Window_i;
            idx       <= '0;
            gx_p1     <= '0;
            gy_p1     <= '0;
        end else if (acc_en) begin
            gx_p1 <= gx_p1 + prod_x;
            gy_p1 <= gy_p1 + prod_y;
            idx   <= (idx == LAST_TAP) ? 4'd0 : idx + 4'd1;
        end
    end

    assign Gx_o = gx_p1;
    assign Gy_o = gy_p1;

    edge_detector_mag #(
        .PIX_W (PIX_W),
        .ACC_W (ACC_W)
    ) u_mag (
        .gx  (gx_p1),
        .gy  (gy_p1),
        .mag (Mag_o)
    );

endmodule

// File: tb/tb_edge_detector_conv.sv
// Randomized self-checking bench for edge_detector_conv with an external
// kernel table and an arithmetic reference model of the convolution.
module tb_edge_detector_conv;

    localparam int PIX_W = 8;
    localparam int ACC_W = 11;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [9*PIX_W-1:0]      window;
    logic                    valid_in;
    logic                    ready_out;
    logic [2:0]              xindex;
    logic [2:0]              yindex;
    logic [2:0]              kx;
    logic [2:0]              ky;
    logic signed [ACC_W-1:0] gx;
    logic signed [ACC_W-1:0] gy;
    logic [PIX_W-1:0]        mag;
    logic                    valid_out;
    logic                    ready_in;

    int checks   = 0;
    int failures = 0;

    int pix[9];
    int kx_tab[9];
    int ky_tab[9];
    int kidx;

    always #5 clk = ~clk;

    edge_detector_conv #(
        .PIX_W (PIX_W),
        .ACC_W (ACC_W)
    ) dut (
        .Clk_i    (clk),
        .Rst_i    (rst),
        .Window_i (window),
        .Valid_i  (valid_in),
        .Ready_o  (ready_out),
        .Xindex_o (xindex),
        .Yindex_o (yindex),
        .Kx_i     (kx),
        .Ky_i     (ky),
        .Gx_o     (gx),
        .Gy_o     (gy),
        .Mag_o    (mag),
        .Valid_o  (valid_out),
        .Ready_i  (ready_in)
    );

    // External coefficient lookup, combinational from the DUT indices.
    assign kidx = int'(xindex) * 3 + int'(yindex);
    always_comb begin
        kx = 3'd0;
        ky = 3'd0;
        if (kidx < 9) begin
            kx = 3'(kx_tab[kidx]);
            ky = 3'(ky_tab[kidx]);
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_sobel();
        kx_tab = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        ky_tab = '{ 1, 2, 1,  0, 0, 0, -1, -2, -1};
    endtask

    function automatic void model(output int egx, output int egy, output int emag);
        int s;
        egx = 0;
        egy = 0;
        for (int i = 0; i < 9; i++) begin
            egx += pix[i] * kx_tab[i];
            egy += pix[i] * ky_tab[i];
        end
        s    = (egx < 0 ? -egx : egx) + (egy < 0 ? -egy : egy);
        emag = (s > 255) ? 255 : s;
    endfunction

    task automatic scramble_window();
        for (int j = 0; j < 9; j++) window[j*PIX_W +: PIX_W] = 8'($urandom);
    endtask

    // Reset asserted together with Valid_i/Ready_i; the block must land in IDLE.
    task automatic reset_and_check(input string tag);
        rst      = 1'b1;
        valid_in = 1'b1;
        ready_in = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        chk({tag, "_rdy"}, ready_out, 1);
        chk({tag, "_vld"}, valid_out, 0);
        chk({tag, "_gx"}, gx, 0);
        chk({tag, "_gy"}, gy, 0);
        chk({tag, "_mag"}, mag, 0);
        chk({tag, "_xidx"}, xindex, 0);
        chk({tag, "_yidx"}, yindex, 0);
    endtask

    // rst_at: -1 none, 0..8 reset during that tap, 9 reset in OUT.
    task automatic run_window(input int hold, input int rst_at);
        int egx, egy, emag;
        model(egx, egy, emag);
        @(negedge clk);
        chk("rdy_idle", ready_out, 1);
        for (int i = 0; i < 9; i++) window[i*PIX_W +: PIX_W] = 8'(pix[i]);
        valid_in = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            if (k == rst_at) begin
                reset_and_check("rst_acc");
                return;
            end
            chk("rdy_acc", ready_out, 0);
            chk("vld_acc", valid_out, 0);
            chk("xidx", xindex, k / 3);
            chk("yidx", yindex, k % 3);
            valid_in = 1'($urandom_range(0, 1));
            ready_in = 1'($urandom_range(0, 1));
            scramble_window();
            @(negedge clk);
        end
        valid_in = 1'b0;
        ready_in = 1'b0;
        chk("vld_out", valid_out, 1);
        chk("rdy_out", ready_out, 0);
        chk("gx", gx, egx);
        chk("gy", gy, egy);
        chk("mag", mag, emag);
        chk("xidx_out", xindex, 0);
        if (rst_at == 9) begin
            reset_and_check("rst_out");
            return;
        end
        for (int h = 0; h < hold; h++) begin
            valid_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("vld_hold", valid_out, 1);
            chk("rdy_hold", ready_out, 0);
            chk("gx_hold", gx, egx);
            chk("gy_hold", gy, egy);
            chk("mag_hold", mag, emag);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        chk("rdy_back", ready_out, 1);
        chk("vld_back", valid_out, 0);
    endtask

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        window   = '0;
        set_sobel();
        repeat (3) @(negedge clk);
        reset_and_check("por");

        pix = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
        run_window(0, -1);

        pix = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
        run_window(1, -1);

        pix = '{10, 10, 10, 0, 0, 0, 0, 0, 0};
        run_window(2, -1);

        pix = '{5, 0, 0, 0, 0, 0, 0, 0, 0};
        run_window(5, -1);

        for (int i = 0; i < 9; i++) pix[i] = $urandom_range(0, 255);
        run_window(0, 4);
        pix = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
        run_window(0, -1);

        for (int i = 0; i < 9; i++) pix[i] = $urandom_range(0, 255);
        run_window(0, 9);

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 9; i++) pix[i] = $urandom_range(0, 255);
            run_window($urandom_range(0, 3), -1);
        end

        // Arbitrary kernels including the -4 code; small pixels keep sums in range.
        kx_tab = '{0, 0, 0, 0, -4, 0, 0, 0, 0};
        ky_tab = '{0, 0, 0, 0, 3, 0, 0, 0, 0};
        pix    = '{0, 0, 0, 0, 200, 0, 0, 0, 0};
        run_window(0, -1);
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 9; i++) begin
                kx_tab[i] = $urandom_range(0, 7) - 4;
                ky_tab[i] = $urandom_range(0, 7) - 4;
                pix[i]    = $urandom_range(0, 28);
            end
            run_window($urandom_range(0, 2), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
